// File: rtl/snake_step_ctrl.sv
// Snake movement-step sequencer: next-head calc, wall check,
// serial self-collision scan and body shift/grow commit.
module snake_step_ctrl #(
  parameter int MAX_LENGTH = 30,
  parameter int LEN_W      = $clog2(MAX_LENGTH+1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       step,
  input  logic [1:0]                 dir,
  input  logic [7:0]                 apple,
  output logic [MAX_LENGTH-1:0][3:0] body_x,
  output logic [MAX_LENGTH-1:0][3:0] body_y,
  output logic [LEN_W-1:0]           length,
  output logic                       busy,
  output logic                       done,
  output logic                       ate,
  output logic                       collision
);

  localparam int IDX_W = $clog2(MAX_LENGTH);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_LENGTH);

  typedef enum logic [1:0] {
    IDLE, SCAN, UPDATE, DEAD
  } state_t;

  state_t state;
  logic [LEN_W-1:0] idx;
  logic [7:0] next_head;

  logic [3:0] hx, hy, nx, ny;
  logic wall;
  logic [IDX_W-1:0] sidx;
  logic seg_hit;

  assign hx = body_x[0];
  assign hy = body_y[0];
  assign sidx = idx[IDX_W-1:0];
  assign seg_hit = ({body_y[sidx], body_x[sidx]} == next_head);

  always_comb begin
    nx = hx;
    ny = hy;
    wall = 1'b0;
    unique case (dir)
      2'b00: begin wall = (hy == 4'd0);  ny = hy - 4'd1; end
      2'b01: begin wall = (hy == 4'd15); ny = hy + 4'd1; end
      2'b10: begin wall = (hx == 4'd0);  nx = hx - 4'd1; end
      2'b11: begin wall = (hx == 4'd15); nx = hx + 4'd1; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= ONE;
      next_head <= '0;
      body_x    <= '0;
      body_y    <= '0;
      body_x[0] <= 4'd8;
      body_x[1] <= 4'd7;
      body_x[2] <= 4'd6;
      body_y[0] <= 4'd8;
      body_y[1] <= 4'd8;
      body_y[2] <= 4'd8;
      length    <= LEN_W'(3);
      busy      <= 1'b0;
      done      <= 1'b0;
      ate       <= 1'b0;
      collision <= 1'b0;
    end else begin
      done <= 1'b0;
      ate  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (step) begin
            next_head <= {ny, nx};
            if (wall) begin
              state     <= DEAD;
              collision <= 1'b1;
              done      <= 1'b1;
            end else begin
              idx   <= ONE;
              busy  <= 1'b1;
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (seg_hit) begin
            state     <= DEAD;
            busy      <= 1'b0;
            collision <= 1'b1;
            done      <= 1'b1;
          end else if (idx == length - ONE) begin
            state <= UPDATE;
          end else begin
            idx <= idx + ONE;
          end
        end
        UPDATE: begin
          // Shift in the new head; the last slot falls off the end.
          body_x <= {body_x[MAX_LENGTH-2:0], next_head[3:0]};
          body_y <= {body_y[MAX_LENGTH-2:0], next_head[7:4]};
          if (next_head == apple) begin
            ate <= 1'b1;
            if (length != MAXL) length <= length + ONE;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        DEAD: ;
      endcase
    end
  end

endmodule

// File: doc/snake_step_ctrl.md
# snake_step_ctrl

Sequencer for one snake movement step. On a step request it computes the next head position from the current direction. It then checks that position against the walls and, serially, against each occupied body segment, one comparison per cycle, replacing the wide all-segments-at-once comparator. It then commits the move by shifting the body array, growing by one when the apple is eaten. It sits between the game tick/direction logic and the body store, and owns the body registers consumed by the display and apple logic.

## Interface
- MAX_LENGTH, 30, number of body segment slots; must be ≥ 3
- LEN_W, $clog2(MAX_LENGTH+1), width of the length counter
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- step  in  1  one-cycle move request; sampled only in IDLE
- dir  in  2  move direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1); sampled with step
- apple  in  8  apple position {y[3:0], x[3:0]}; sampled in UPDATE
- body_x  out  [MAX_LENGTH-1:0][3:0]  segment x positions; index 0 = head
- body_y  out  [MAX_LENGTH-1:0][3:0]  segment y positions; index 0 = head
- length  out  LEN_W  number of occupied segments
- busy  out  1  high in SCAN and UPDATE
- done  out  1  one-cycle pulse; step finished (moved or died)
- ate  out  1  one-cycle pulse coincident with done when the apple was eaten
- collision  out  1  sticky game-over flag

## Operation
- The reset values below are decided:
  - body[0]=(8,8), body[1]=(7,8), body[2]=(6,8) as (x,y); all other segments (0,0).
  - length=3.
  - busy, done, ate and collision are all 0.
  - The state machine starts in IDLE.
- States: IDLE, SCAN, UPDATE, DEAD. All outputs are registered.
- IDLE:
  - On step=1, latch next_head.
    - next_head is body[0] stepped by dir.
    - Arithmetic is 4-bit with no wrap.
  - A wall hit occurs on x=0 with left, x=15 with right, y=0 with up, or y=15 with down.
    - On a wall hit, go to DEAD and set collision=1 and done=1.
  - Otherwise, set idx=1 and go to SCAN.
  - With step=0, stay in IDLE.
- SCAN:
  - Each cycle, compare {body_y[idx], body_x[idx]} with next_head (all 8 bits equal).
  - Match: go to DEAD and set collision=1 and done=1.
  - No match and idx = length-1: go to UPDATE.
  - Otherwise: idx++.
  - Only indices 1..length-1 are compared. The tail is included, which is conservative: a move into the cell being vacated counts as a collision.
- UPDATE:
  - For i = MAX_LENGTH-1 down to 1: body[i] ← body[i-1]. Then body[0] ← next_head.
  - If next_head == apple:
    - ate=1.
    - length ← length+1, saturating at MAX_LENGTH. ate still pulses when saturated.
  - Set done=1 and go to IDLE.
- DEAD:
  - Terminal. step is ignored, body and length are frozen, and collision stays 1.
  - Only rst leaves DEAD.
- A reverse move (dir opposite to the current heading) targets body[1], so it is caught in SCAN as a self-collision. No special case is needed.
- On collision, the body and length are not modified.
- step asserted while busy, in DEAD, or in the done cycle's successor state is ignored.
  - A step in the IDLE cycle where done=1 **is** accepted.

## Timing
- Take the step-sampling edge as E0.
- SCAN occupies cycles E0+1 … E0+length-1 (length-1 cycles), then UPDATE is one cycle.
- Successful move:
  - done=1 (and ate, if applicable) during cycle E0+length+1.
  - The new body and length are visible in that same cycle.
  - Total latency is length+1 cycles. For length=3, done appears 4 cycles after the step edge.
- Wall collision: collision=1 and done=1 in cycle E0+1.
- Self-collision at index k: collision=1 and done=1 in cycle E0+k+1.
- busy=1 exactly in the SCAN and UPDATE cycles.
- done and ate are high for exactly one cycle.
- rst asserted in any state, including mid-SCAN: the next cycle shows reset values, with no done pulse.
- Back-to-back moves: the minimum step spacing is length+1 cycles.

## Test plan
- Reset, then step with dir=11 and apple=(0,0):
  - done appears 4 cycles after the step.
  - body[0..2] = (9,8),(8,8),(7,8).
  - length=3, ate=0, collision=0.
- From reset, step with dir=11 and apple=(9,8):
  - ate=1 together with done.
  - length=4, body[3]=(6,8).
- From reset, step with dir=10 (reversal into body[1]):
  - collision=1 and done=1 at E0+2 (k=1).
  - body is unchanged, and a later step produces no response.
- Drive the head to x=15 heading right, then step with dir=11:
  - collision=1 and done=1 in cycle E0+1.
  - busy is never asserted.
- Grow to length=MAX_LENGTH, then eat again:
  - length stays at MAX_LENGTH and ate=1.
  - The scan takes MAX_LENGTH-1 cycles.
- Assert step during busy:
  - It is ignored, and exactly one done pulse occurs.
- Assert rst mid-SCAN:
  - Next cycle: reset body, length=3, busy=0, done=0.
